pwm_duty_sequencer: RTL and testbench



---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_duty_sequencer_if.sv | 24 ++
 rtl/pwm_boton_repeat.sv | 39 +++
 rtl/pwm_duty_sequencer.sv | 150 +++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty path: duty width, counter wrap value
// and the sequencer state encoding.
package pwm_pkg;

    localparam int DUTY_W  = 6;
    localparam int PWM_MAX = 50;

    typedef logic [DUTY_W-1:0]      duty_t;
    typedef logic signed [DUTY_W:0] duty_ext_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        OFF  = 2'd2
    } estado_t;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Control/status bundle between the duty sequencer and its environment
// (period tick, enable, pushbuttons in; duty word and status out).
interface pwm_duty_sequencer_if;

    logic                       Tick_Periodo;
    logic                       Enable;
    logic                       Boton_Up;
    logic                       Boton_Down;
    logic [pwm_pkg::DUTY_W-1:0] Q;
    logic [pwm_pkg::DUTY_W-1:0] Objetivo;
    logic                       Busy;
    logic                       Limite;

    modport master (
        output Tick_Periodo, Enable, Boton_Up, Boton_Down,
        input  Q, Objetivo, Busy, Limite
    );

    modport slave (
        input  Tick_Periodo, Enable, Boton_Up, Boton_Down,
        output Q, Objetivo, Busy, Limite
    );

endinterface

// File: rtl/pwm_boton_repeat.sv
// One pushbutton: rising-edge event plus auto-repeat every REPEAT_PER
// period ticks while held alone. Event is a one-CLK combinational pulse.
module pwm_boton_repeat #(
    parameter int REPEAT_PER = 25
) (
    input  logic CLK,
    input  logic Reset,
    input  logic tick,
    input  logic boton,
    input  logic otro,
    output logic evento
);

    localparam int CNT_W = $clog2(REPEAT_PER + 1);

    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             solo;
    logic             rep;

    // Holding the other button at the same time masks events and repeats.
    assign solo   = boton & ~otro;
    assign rep    = tick && (cnt == CNT_W'(REPEAT_PER - 1));
    assign evento = solo & (~prev | rep);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= boton;
            if (!solo)
                cnt <= '0;
            else if (tick)
                cnt <= rep ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Pushbutton-driven duty target with period-aligned unit-step ramping of
// the applied duty word Q.
//
//   state | meaning
//   IDLE  | Q equals effective target; Busy low
//   RAMP  | Q steps 1 toward target every RAMP_DIV period ticks
//   OFF   | Enable low; Q forced to 0 on the next period tick
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int MAX_DUTY   = PWM_MAX,
    parameter int STEP       = 5,
    parameter int RAMP_DIV   = 4,
    parameter int REPEAT_PER = 25
) (
    input logic                 CLK,
    input logic                 Reset,
    pwm_duty_sequencer_if.slave bus
);

    localparam int        DIV_W  = $clog2(RAMP_DIV + 1);
    localparam duty_ext_t STEP_S = duty_ext_t'(STEP);
    localparam duty_ext_t MAX_S  = duty_ext_t'(MAX_DUTY);
    localparam duty_t     MAX_Q  = duty_t'(MAX_DUTY);

    estado_t          estado;
    duty_t            q;
    duty_t            obj;
    duty_t            obj_nxt;
    duty_t            eff;
    duty_t            q_paso;
    duty_t            q_off;
    logic             busy;
    logic             limite;
    logic [DIV_W-1:0] div;
    logic             ev_up;
    logic             ev_dn;
    duty_ext_t        suma;
    duty_ext_t        resta;

    pwm_boton_repeat #(.REPEAT_PER(REPEAT_PER)) u_up (
        .CLK    (CLK),
        .Reset  (Reset),
        .tick   (bus.Tick_Periodo),
        .boton  (bus.Boton_Up),
        .otro   (bus.Boton_Down),
        .evento (ev_up)
    );

    pwm_boton_repeat #(.REPEAT_PER(REPEAT_PER)) u_dn (
        .CLK    (CLK),
        .Reset  (Reset),
        .tick   (bus.Tick_Periodo),
        .boton  (bus.Boton_Down),
        .otro   (bus.Boton_Up),
        .evento (ev_dn)
    );

    // Signed 7-bit intermediates so neither end can wrap.
    always_comb begin
        suma    = $signed({1'b0, obj}) + STEP_S;
        resta   = $signed({1'b0, obj}) - STEP_S;
        obj_nxt = obj;
        if (ev_up)
            obj_nxt = (suma > MAX_S) ? MAX_Q : duty_t'(suma);
        else if (ev_dn)
            obj_nxt = resta[DUTY_W] ? '0 : duty_t'(resta);
    end

    assign eff    = bus.Enable ? obj : '0;
    assign q_paso = (eff > q) ? q + duty_t'(1) : q - duty_t'(1);
    assign q_off  = bus.Tick_Periodo ? '0 : q;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            estado <= IDLE;
            q      <= '0;
            obj    <= '0;
            div    <= '0;
            busy   <= 1'b0;
            limite <= 1'b1;
        end else begin
            obj    <= obj_nxt;
            limite <= (obj_nxt == '0) || (obj_nxt == MAX_Q);
            case (estado)
                IDLE: begin
                    div <= '0;
                    if (!bus.Enable) begin
                        estado <= OFF;
                        busy   <= (q != '0);
                    end else if (q != eff) begin
                        estado <= RAMP;
                        busy   <= 1'b1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                RAMP: begin
                    if (!bus.Enable) begin
                        estado <= OFF;
                        div    <= '0;
                        busy   <= (q != '0);
                    end else if (q == eff) begin
                        estado <= IDLE;
                        div    <= '0;
                        busy   <= 1'b0;
                    end else if (bus.Tick_Periodo) begin
                        // Divider keeps running across target changes.
                        if (div == DIV_W'(RAMP_DIV - 1)) begin
                            div <= '0;
                            q   <= q_paso;
                            if (q_paso == eff) begin
                                estado <= IDLE;
                                busy   <= 1'b0;
                            end else begin
                                busy   <= 1'b1;
                            end
                        end else begin
                            div  <= div + 1'b1;
                            busy <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                OFF: begin
                    div <= '0;
                    q   <= q_off;
                    if (bus.Enable) begin
                        estado <= (q_off != obj) ? RAMP : IDLE;
                        busy   <= (q_off != obj);
                    end else begin
                        busy   <= (q_off != '0);
                    end
                end
                default: begin
                    estado <= IDLE;
                    div    <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q        = q;
    assign bus.Objetivo = obj;
    assign bus.Busy     = busy;
    assign bus.Limite   = limite;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: behavioural model checked every
// cycle plus hand-computed expectations at key points.
module tb_pwm_duty_sequencer;
    import pwm_pkg::*;

    localparam int MAX_DUTY   = 50;
    localparam int STEP       = 5;
    localparam int RAMP_DIV   = 4;
    localparam int REPEAT_PER = 25;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pwm_duty_sequencer_if bus ();

    pwm_duty_sequencer #(
        .MAX_DUTY   (MAX_DUTY),
        .STEP       (STEP),
        .RAMP_DIV   (RAMP_DIV),
        .REPEAT_PER (REPEAT_PER)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Model: target = saturating sum of button events; Q moves one count
    // per RAMP_DIV ticks spent ramping; Busy = Q differs from the target
    // that applied at that edge; Enable low zeroes Q at the next tick.
    int    m_q = 0, m_obj = 0, m_div = 0, h_up = 0, h_dn = 0;
    bit    m_busy = 0, m_lim = 1, m_off = 0, p_up = 0, p_dn = 0;
    bit    m_valid = 0, e_tick = 0, e_rst = 0;
    duty_t q_last = '0;
    bit    q_last_ok = 0;

    always @(posedge CLK) begin
        int  eff;
        bit  ev_u, ev_d, up, dn, tk, en;
        up = bus.Boton_Up;
        dn = bus.Boton_Down;
        tk = bus.Tick_Periodo;
        en = bus.Enable;
        e_tick = tk;
        e_rst  = Reset;
        if (!Reset) begin
            m_q = 0; m_obj = 0; m_div = 0; h_up = 0; h_dn = 0;
            m_busy = 0; m_lim = 1; m_off = 0; p_up = 0; p_dn = 0;
            m_valid = 1;
        end else begin
            ev_u = 0;
            ev_d = 0;
            if (up && !dn) begin
                if (tk) h_up++;
                if (h_up == REPEAT_PER) begin ev_u = 1; h_up = 0; end
                if (!p_up) ev_u = 1;
            end else h_up = 0;
            if (dn && !up) begin
                if (tk) h_dn++;
                if (h_dn == REPEAT_PER) begin ev_d = 1; h_dn = 0; end
                if (!p_dn) ev_d = 1;
            end else h_dn = 0;
            p_up = up;
            p_dn = dn;
            eff = en ? m_obj : 0;
            if (m_off) begin
                if (tk) m_q = 0;
                m_div = 0;
            end else if (en && m_busy && m_q != eff) begin
                if (tk) begin
                    m_div++;
                    if (m_div == RAMP_DIV) begin
                        m_div = 0;
                        m_q = (eff > m_q) ? m_q + 1 : m_q - 1;
                    end
                end
            end else m_div = 0;
            m_busy = (m_q != eff);
            m_off  = !en;
            if (ev_u) m_obj = (m_obj + STEP > MAX_DUTY) ? MAX_DUTY : m_obj + STEP;
            if (ev_d) m_obj = (m_obj - STEP < 0) ? 0 : m_obj - STEP;
            m_lim = (m_obj == 0) || (m_obj == MAX_DUTY);
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            n_checks++;
            if (bus.Q !== duty_t'(m_q) || bus.Objetivo !== duty_t'(m_obj) ||
                bus.Busy !== m_busy || bus.Limite !== m_lim) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got Q=%0d Obj=%0d Busy=%0b Lim=%0b expected Q=%0d Obj=%0d Busy=%0b Lim=%0b",
                         $time, bus.Q, bus.Objetivo, bus.Busy, bus.Limite, m_q, m_obj, m_busy, m_lim);
            end
            if (q_last_ok && e_rst && !e_tick) begin
                n_checks++;
                if (bus.Q !== q_last) begin
                    n_fail++;
                    $display("FAIL q_between_ticks t=%0t: got Q=%0d expected unchanged %0d", $time, bus.Q, q_last);
                end
            end
            q_last    = bus.Q;
            q_last_ok = 1;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Tick_Periodo = 1'b1;
            step();
            bus.Tick_Periodo = 1'b0;
            step();
            step();
        end
    endtask

    task automatic press_up();
        bus.Boton_Up = 1'b1;
        step();
        bus.Boton_Up = 1'b0;
        step();
    endtask

    task automatic press_dn();
        bus.Boton_Down = 1'b1;
        step();
        bus.Boton_Down = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.Tick_Periodo = 1'b0;
        bus.Enable       = 1'b1;
        bus.Boton_Up     = 1'b0;
        bus.Boton_Down   = 1'b0;
        Reset            = 1'b0;
        repeat (3) step();
        chk("reset_q", int'(bus.Q), 0);
        chk("reset_obj", int'(bus.Objetivo), 0);
        chk("reset_busy", int'(bus.Busy), 0);
        chk("reset_lim", int'(bus.Limite), 1);
        Reset = 1'b1;
        step();

        // single press and 20-tick ramp to 5
        bus.Boton_Up = 1'b1;
        step();
        chk("press_obj", int'(bus.Objetivo), 5);
        chk("press_busy_same_edge", int'(bus.Busy), 0);
        chk("press_lim", int'(bus.Limite), 0);
        bus.Boton_Up = 1'b0;
        step();
        chk("ramp_busy", int'(bus.Busy), 1);
        ticks(3);
        chk("ramp_q_tick3", int'(bus.Q), 0);
        ticks(1);
        chk("ramp_q_tick4", int'(bus.Q), 1);
        ticks(15);
        chk("ramp_q_tick19", int'(bus.Q), 4);
        chk("ramp_busy_tick19", int'(bus.Busy), 1);
        ticks(1);
        chk("ramp_q_tick20", int'(bus.Q), 5);
        chk("ramp_busy_tick20", int'(bus.Busy), 0);

        // saturation at both ends
        for (int i = 0; i < 8; i++) press_up();
        chk("obj_45", int'(bus.Objetivo), 45);
        chk("lim_45", int'(bus.Limite), 0);
        press_up();
        chk("obj_sat_50", int'(bus.Objetivo), 50);
        chk("lim_50", int'(bus.Limite), 1);
        press_up();
        chk("obj_stay_50", int'(bus.Objetivo), 50);
        for (int i = 0; i < 9; i++) press_dn();
        chk("obj_5", int'(bus.Objetivo), 5);
        chk("lim_5", int'(bus.Limite), 0);
        press_dn();
        chk("obj_0", int'(bus.Objetivo), 0);
        chk("lim_0", int'(bus.Limite), 1);
        press_dn();
        chk("obj_stay_0", int'(bus.Objetivo), 0);

        // auto-repeat while held
        bus.Boton_Up = 1'b1;
        step();
        chk("hold_press", int'(bus.Objetivo), 5);
        ticks(24);
        chk("hold_tick24", int'(bus.Objetivo), 5);
        ticks(1);
        chk("hold_tick25", int'(bus.Objetivo), 10);
        ticks(24);
        chk("hold_tick49", int'(bus.Objetivo), 10);
        ticks(1);
        chk("hold_tick50", int'(bus.Objetivo), 15);
        ticks(10);
        chk("hold_tick60", int'(bus.Objetivo), 15);
        bus.Boton_Up = 1'b0;
        step();
        bus.Boton_Up = 1'b1;
        step();
        chk("repress_obj", int'(bus.Objetivo), 20);
        ticks(24);
        chk("repress_tick24", int'(bus.Objetivo), 20);
        ticks(1);
        chk("repress_tick25", int'(bus.Objetivo), 25);
        bus.Boton_Up = 1'b0;
        step();

        // both buttons together
        bus.Boton_Up   = 1'b1;
        bus.Boton_Down = 1'b1;
        step();
        chk("both_press", int'(bus.Objetivo), 25);
        ticks(30);
        chk("both_held", int'(bus.Objetivo), 25);
        bus.Boton_Up   = 1'b0;
        bus.Boton_Down = 1'b0;
        step();

        // enable off/on at Q=30
        press_up();
        chk("obj_30", int'(bus.Objetivo), 30);
        guard = 0;
        while (!(bus.Q == 6'd30 && bus.Busy == 1'b0) && guard < 200) begin
            ticks(1);
            guard++;
        end
        chk("settle_q30", int'(bus.Q), 30);
        chk("settle_busy", int'(bus.Busy), 0);
        bus.Enable = 1'b0;
        step();
        chk("off_busy", int'(bus.Busy), 1);
        step();
        step();
        chk("off_q_before_tick", int'(bus.Q), 30);
        ticks(1);
        chk("off_q_tick", int'(bus.Q), 0);
        chk("off_obj_kept", int'(bus.Objetivo), 30);
        chk("off_busy_tick", int'(bus.Busy), 0);
        bus.Enable = 1'b1;
        step();
        chk("on_busy", int'(bus.Busy), 1);
        ticks(3);
        chk("on_q_tick3", int'(bus.Q), 0);
        ticks(1);
        chk("on_q_tick4", int'(bus.Q), 1);

        // reset in the middle of the ramp
        guard = 0;
        while (bus.Q != 6'd17 && guard < 200) begin
            ticks(1);
            guard++;
        end
        chk("midramp_q17", int'(bus.Q), 17);
        Reset = 1'b0;
        step();
        chk("midreset_q", int'(bus.Q), 0);
        chk("midreset_obj", int'(bus.Objetivo), 0);
        chk("midreset_busy", int'(bus.Busy), 0);
        chk("midreset_lim", int'(bus.Limite), 1);
        step();
        Reset = 1'b1;
        step();
        ticks(2);
        chk("post_reset_q", int'(bus.Q), 0);
        chk("post_reset_busy", int'(bus.Busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
